// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifu_fifo.sv
// Return buffer for fetched {pc, instr} entries: synchronous FIFO with flush.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A flush discards the entry arriving in the same cycle as well.
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);
    assign head    = mem[rd_ptr];

    // Entry storage; reset contents are never presented as valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '{pc: '0, instr: NOP_INSTR};
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks the fetch PC, issues fixed-latency BRAM reads,
// buffers returned words and hands {pc, instr} to the core over valid/ready.
// Optional feature macro: IFU_MISALIGN_CHECK_EN (sticky misaligned-redirect stop).
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ADDR_W      = 12,
    parameter int          MEM_LATENCY = 2,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic              clk_100mhz,
    input  logic              rst_in,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       instr_out,
    output logic [31:0]       pc_out,
    output logic              instr_valid_out,
    input  logic              instr_ready_in,
    output logic              imem_en_out,
    output logic [ADDR_W-1:0] imem_addr_out,
    input  logic [31:0]       imem_data_in
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic              misalign_out
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t           state;
    fetch_state_t           state_next;
    logic [31:0]            fetch_pc;
    logic                   epoch;
    logic [MEM_LATENCY-1:0] pipe_valid;
    logic [MEM_LATENCY-1:0] pipe_epoch;
    logic [31:0]            pipe_pc [MEM_LATENCY];
    logic [CW-1:0]          fifo_count;
    fetch_entry_t           fifo_head;
    logic                   fifo_empty;
    logic                   issue;
    logic                   credit;
    logic                   push;
    logic                   pop;
    logic                   bad_redirect;
    logic                   halted;
    logic [31:0]            redirect_target;
    int unsigned            inflight;

`ifdef IFU_MISALIGN_CHECK_EN
    logic misalign;

    assign bad_redirect    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
    assign halted          = misalign;
    assign misalign_out    = misalign;

    // Sticky misalign flag; only a later redirect (or reset) re-evaluates it.
    always_ff @(posedge clk_100mhz or negedge rst_in) begin
        if (!rst_in)             misalign <= 1'b0;
        else if (redirect_valid) misalign <= bad_redirect;
    end
`else
    assign bad_redirect    = 1'b0;
    assign redirect_target = redirect_pc & ~32'h3;
    assign halted          = 1'b0;
`endif

    // Reads issued but not yet returned, stale-epoch ones included (conservative credit).
    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
            inflight += 32'(pipe_valid[i]);
        end
    end

    assign credit = (inflight + 32'(fifo_count)) < 32'(FIFO_DEPTH);

    // Next-state and issue decision; a redirect overrides everything that cycle.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        if (redirect_valid) begin
            state_next = bad_redirect ? S_HOLD : S_FETCH;
        end else begin
            case (state)
                S_BOOT:  state_next = S_FETCH;
                S_FETCH: begin
                    if (credit && !halted) issue = 1'b1;
                    else                   state_next = S_HOLD;
                end
                S_HOLD:  if (credit && !halted) state_next = S_FETCH;
                default: state_next = S_BOOT;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_100mhz or negedge rst_in) begin
        if (!rst_in) state <= S_BOOT;
        else         state <= state_next;
    end

    // Fetch PC and epoch; a redirect restarts the stream and invalidates older reads.
    always_ff @(posedge clk_100mhz or negedge rst_in) begin
        if (!rst_in) begin
            fetch_pc <= RESET_PC;
            epoch    <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            epoch    <= ~epoch;
        end else if (issue) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // In-flight pipe: tail lines up with imem_data_in for the same read.
    always_ff @(posedge clk_100mhz or negedge rst_in) begin
        if (!rst_in) begin
            pipe_valid <= '0;
            pipe_epoch <= '0;
            for (int unsigned i = 0; i < MEM_LATENCY; i++) pipe_pc[i] <= '0;
        end else begin
            pipe_valid[0] <= issue;
            pipe_epoch[0] <= epoch;
            pipe_pc[0]    <= fetch_pc;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_epoch[i] <= pipe_epoch[i-1];
                pipe_pc[i]    <= pipe_pc[i-1];
            end
        end
    end

    assign push = pipe_valid[MEM_LATENCY-1] && (pipe_epoch[MEM_LATENCY-1] == epoch);

    ifu_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_100mhz),
        .rst_n    (rst_in),
        .flush    (redirect_valid),
        .push     (push),
        .push_data('{pc: pipe_pc[MEM_LATENCY-1], instr: imem_data_in}),
        .pop      (pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    assign fifo_empty      = (fifo_count == '0);
    assign instr_valid_out = !fifo_empty && !redirect_valid;
    assign pop             = instr_valid_out && instr_ready_in;
    assign pc_out          = fifo_empty ? RESET_PC : fifo_head.pc;
    assign instr_out       = fifo_empty ? '0 : fifo_head.instr;
    assign imem_en_out     = issue;
    assign imem_addr_out   = fetch_pc[ADDR_W+1:2];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 2-cycle BRAM model.
// Define IFU_MISALIGN_CHECK_EN for both RTL and bench to exercise the misalign stop.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic        imem_en_out;
    logic [11:0] imem_addr_out;
    logic [31:0] imem_data_in;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        misalign_out;
`endif

    int total = 0;
    int bad   = 0;
    int issues;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .ADDR_W     (12),
        .MEM_LATENCY(2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_100mhz     (clk),
        .rst_in         (rst_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .instr_valid_out(instr_valid_out),
        .instr_ready_in (instr_ready_in),
        .imem_en_out    (imem_en_out),
        .imem_addr_out  (imem_addr_out),
        .imem_data_in   (imem_data_in)
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        .misalign_out   (misalign_out)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return 32'h0010_0093 + ({20'b0, a} << 20);
    endfunction

    // BRAM model: read data valid two cycles after the enable; junk otherwise.
    logic [31:0] d1, d2;
    always @(posedge clk) begin
        d1 <= imem_en_out ? mem_word(imem_addr_out) : 32'hDEAD_BEEF;
        d2 <= d1;
    end
    assign imem_data_in = d2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_in         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready_in = 1'b1;

        // Reset state
        step();
        chk("rst_valid", 32'(instr_valid_out), 32'd0);
        chk("rst_en",    32'(imem_en_out),     32'd0);
        chk("rst_pc",    pc_out,               32'h0);
        chk("rst_instr", instr_out,            32'h0);

        // 1: release with ready=1, stream 0,4,8,C
        rst_in = 1'b1;
        #1;
        chk("t1_boot_en", 32'(imem_en_out), 32'd0);
        step();
        chk("t1_c1_en",   32'(imem_en_out),   32'd1);
        chk("t1_c1_addr", 32'(imem_addr_out), 32'd0);
        step();
        chk("t1_c2_addr",  32'(imem_addr_out),   32'd1);
        chk("t1_c2_valid", 32'(instr_valid_out), 32'd0);
        step();
        chk("t1_c3_valid", 32'(instr_valid_out), 32'd0);
        step();
        chk("t1_c4_valid", 32'(instr_valid_out), 32'd1);
        chk("t1_c4_pc",    pc_out,               32'h0);
        chk("t1_c4_instr", instr_out,            mem_word(12'd0));
        for (int i = 1; i < 4; i++) begin
            step();
            chk("t1_stream_valid", 32'(instr_valid_out), 32'd1);
            chk("t1_stream_pc",    pc_out,               32'(i * 4));
            chk("t1_stream_instr", instr_out,            mem_word(12'(i)));
        end

        // 2: ready=0 from release -> exactly 4 issues, then drain in order
        rst_in = 1'b0;
        step();
        step();
        instr_ready_in = 1'b0;
        rst_in         = 1'b1;
        issues         = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (imem_en_out) issues++;
        end
        chk("t2_issues",   32'(issues),          32'd4);
        chk("t2_en_off",   32'(imem_en_out),     32'd0);
        chk("t2_valid",    32'(instr_valid_out), 32'd1);
        chk("t2_head_pc",  pc_out,               32'h0);
        chk("t2_head_ins", instr_out,            mem_word(12'd0));
        instr_ready_in = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("t2_drain_pc",  pc_out,    32'(i * 4));
            chk("t2_drain_ins", instr_out, mem_word(12'(i)));
        end
        step();
        chk("t2_gap_valid", 32'(instr_valid_out), 32'd0);
        step();
        chk("t2_resume_valid", 32'(instr_valid_out), 32'd1);
        chk("t2_resume_pc",    pc_out,               32'h10);

        // 3: redirect to 0x100 mid-stream
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("t3_redir_valid", 32'(instr_valid_out), 32'd0);
        chk("t3_redir_en",    32'(imem_en_out),     32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t3_issue_en",   32'(imem_en_out),     32'd1);
        chk("t3_issue_addr", 32'(imem_addr_out),   32'h40);
        chk("t3_r1_valid",   32'(instr_valid_out), 32'd0);
        step();
        chk("t3_r2_valid", 32'(instr_valid_out), 32'd0);
        step();
        chk("t3_r3_valid", 32'(instr_valid_out), 32'd0);
        step();
        chk("t3_first_valid", 32'(instr_valid_out), 32'd1);
        chk("t3_first_pc",    pc_out,               32'h100);
        chk("t3_first_ins",   instr_out,            mem_word(12'h40));
        step();
        chk("t3_next_pc", pc_out, 32'h104);

        // 4: back-to-back redirects 0x200 then 0x300
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        chk("t4_s0_valid", 32'(instr_valid_out), 32'd0);
        step();
        redirect_pc = 32'h300;
        #1;
        chk("t4_s1_valid", 32'(instr_valid_out), 32'd0);
        chk("t4_s1_en",    32'(imem_en_out),     32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t4_issue_addr", 32'(imem_addr_out),   32'hC0);
        chk("t4_s2_valid",   32'(instr_valid_out), 32'd0);
        step();
        chk("t4_s3_valid", 32'(instr_valid_out), 32'd0);
        step();
        chk("t4_s4_valid", 32'(instr_valid_out), 32'd0);
        step();
        chk("t4_first_valid", 32'(instr_valid_out), 32'd1);
        chk("t4_first_pc",    pc_out,               32'h300);
        chk("t4_first_ins",   instr_out,            mem_word(12'hC0));

        // 5: reset with the FIFO full, then restart at RESET_PC
        instr_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("t5_full_valid", 32'(instr_valid_out), 32'd1);
        chk("t5_full_pc",    pc_out,               32'h300);
        rst_in = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(instr_valid_out), 32'd0);
        chk("t5_rst_en",    32'(imem_en_out),     32'd0);
        chk("t5_rst_pc",    pc_out,               32'h0);
        step();
        step();
        instr_ready_in = 1'b1;
        rst_in         = 1'b1;
        #1;
        chk("t5_boot_en", 32'(imem_en_out), 32'd0);
        step();
        chk("t5_c1_addr", 32'(imem_addr_out), 32'd0);
        step();
        step();
        chk("t5_c3_valid", 32'(instr_valid_out), 32'd0);
        step();
        chk("t5_c4_valid", 32'(instr_valid_out), 32'd1);
        chk("t5_c4_pc",    pc_out,               32'h0);
        chk("t5_c4_ins",   instr_out,            mem_word(12'd0));

`ifdef IFU_MISALIGN_CHECK_EN
        // 6: misaligned redirect stops fetch until an aligned redirect
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        #1;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t6_mis_flag", 32'(misalign_out), 32'd1);
        chk("t6_mis_en",   32'(imem_en_out),  32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("t6_mis_en_late", 32'(imem_en_out),     32'd0);
        chk("t6_mis_valid",   32'(instr_valid_out), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h104;
        #1;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t6_clr_flag", 32'(misalign_out),  32'd0);
        chk("t6_clr_en",   32'(imem_en_out),   32'd1);
        chk("t6_clr_addr", 32'(imem_addr_out), 32'h41);
        step();
        step();
        step();
        chk("t6_first_valid", 32'(instr_valid_out), 32'd1);
        chk("t6_first_pc",    pc_out,               32'h104);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
